// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/interrupt controller.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W        = 4;
    localparam int INT_DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEMWAIT    = 2'd1,
        INT_DRAIN  = 2'd2,
        INT_INJECT = 2'd3
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the ID sources and the EX load destination.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_reg_dst,
    input  logic                 ex_mem_rd,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1 == ex_reg_dst);
        rs2_hit  = id_use_rs2 && (id_rs2 == ex_reg_dst);
        // x0 is hardwired, so a load "targeting" it never produces data to wait for
        load_use = ex_mem_rd && (ex_reg_dst != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: memory wait, redirect, load-use and interrupt sequencing.
// Interrupt sequencing is built only when PIPE_INT_SEQ_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [3:0] ex_reg_dst,
    input  logic       ex_mem_rd,
    input  logic       ex_redirect,
    input  logic       mem_req,
    input  logic       mem_ready,
    input  logic       int_req,
    output logic       int_ack,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       int_inject,
    output logic [1:0] state_o
);

    state_e state_q, state_d;
    state_e resume_q, resume_d;
    state_e eff_state;
    logic   load_use;
    logic   mem_wait;

`ifdef PIPE_INT_SEQ_EN
    localparam int CNT_W = $clog2(INT_DRAIN_CYCLES + 1);
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_int_req;
    assign unused_int_req = int_req;
`endif

    hazard_detect u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_reg_dst (ex_reg_dst),
        .ex_mem_rd  (ex_mem_rd),
        .load_use   (load_use)
    );

    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        int_inject  = 1'b0;
        int_ack     = 1'b0;
`ifdef PIPE_INT_SEQ_EN
        pending_d   = pending_q;
        cnt_d       = cnt_q;
`endif
        mem_wait  = mem_req && !mem_ready;
        // The mem_ready cycle behaves exactly like the state the wait interrupted
        eff_state = (state_q == MEMWAIT) ? resume_q : state_q;

        if (mem_wait) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
            state_d     = MEMWAIT;
            if (state_q != MEMWAIT) begin
                resume_d = state_q;
            end
        end else begin
            state_d = eff_state;
            if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            case (eff_state)
`ifdef PIPE_INT_SEQ_EN
                RUN: begin
                    if (int_req && !pending_q && !ex_redirect && !load_use) begin
                        pending_d = 1'b1;
                        cnt_d     = CNT_W'(INT_DRAIN_CYCLES);
                        state_d   = INT_DRAIN;
                    end
                end
                INT_DRAIN: begin
                    // A redirect must be allowed to load its target, so it releases the PC
                    pc_stall    = !ex_redirect;
                    if_id_stall = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = ex_redirect;
                    cnt_d       = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        state_d = INT_INJECT;
                    end
                end
                INT_INJECT: begin
                    int_inject = 1'b1;
                    int_ack    = 1'b1;
                    pending_d  = 1'b0;
                    state_d    = RUN;
                end
`endif
                default: ;
            endcase
        end

        if (rst) begin
            pc_stall    = 1'b0;
            if_id_stall = 1'b0;
            if_id_flush = 1'b0;
            id_ex_stall = 1'b0;
            id_ex_flush = 1'b0;
            int_inject  = 1'b0;
            int_ack     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            resume_q <= RUN;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
        end
    end

`ifdef PIPE_INT_SEQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end
`endif

    assign state_o = state_q;

endmodule
